// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state codes, the HALT word
// and word/byte geometry helpers.
package program_loader_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Wide enough for any supported word width; sliced to RAM_WIDTH by users.
    localparam logic [63:0] HALT_WORD = 64'd0;

    function automatic int bytes_per_word(input int ram_width);
        return ram_width / 8;
    endfunction

    function automatic int byte_idx_width(input int bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Shifts received bytes MSB-first into an instruction word and flags the byte
// that completes it; word carries the completed value in that same cycle.
module program_loader_byte_assembler
    import program_loader_pkg::*;
#(
    parameter int RAM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [7:0]           rx_data,
    output logic [RAM_WIDTH-1:0] word,
    output logic                 word_valid
);

    localparam int BPW   = bytes_per_word(RAM_WIDTH);
    localparam int IDX_W = byte_idx_width(BPW);

    logic [RAM_WIDTH-1:0] shift_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 last_s;

    // Next word value and completion flag for the byte currently offered.
    always_comb begin
        word       = (shift_r << 8) | RAM_WIDTH'(rx_data);
        last_s     = (idx_r == IDX_W'(BPW - 1));
        word_valid = shift_en && last_s;
    end

    // Shift register and byte index; clear restarts assembly at byte 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {RAM_WIDTH{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else if (clear) begin
            shift_r <= {RAM_WIDTH{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else if (shift_en) begin
            shift_r <= word;
            idx_r   <= last_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end else begin
            shift_r <= shift_r;
            idx_r   <= idx_r;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a UART byte stream into program memory as RAM_WIDTH-bit words at
// consecutive addresses, stopping on the HALT word or when memory is full.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int RAM_WIDTH     = 16,
    parameter int RAM_ADDR_BITS = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               rx_data,
    input  logic                     rx_done,
    output logic                     wr_en,
    output logic [RAM_ADDR_BITS-1:0] wr_addr,
    output logic [RAM_WIDTH-1:0]     wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [RAM_ADDR_BITS:0]   words_loaded
);

    logic [1:0]               state_r;
    logic [1:0]               state_s;
    logic [RAM_ADDR_BITS-1:0] addr_r;
    logic                     start_ok_s;
    logic                     is_halt_s;
    logic                     at_last_s;
    logic                     continue_s;
    logic                     shift_en_s;
    logic                     word_valid_s;
    logic [RAM_WIDTH-1:0]     word_s;

    logic                     wr_en_r;
    logic [RAM_ADDR_BITS-1:0] wr_addr_r;
    logic [RAM_WIDTH-1:0]     wr_data_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     overflow_r;
    logic [RAM_ADDR_BITS:0]   words_r;

    program_loader_byte_assembler #(
        .RAM_WIDTH (RAM_WIDTH)
    ) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok_s),
        .shift_en   (shift_en_s),
        .rx_data    (rx_data),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Next-state logic; a byte arriving during WRITE is kept only if loading continues.
    always_comb begin
        start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        is_halt_s  = (wr_data_r == HALT_WORD[RAM_WIDTH-1:0]);
        at_last_s  = (addr_r == {RAM_ADDR_BITS{1'b1}});
        continue_s = !is_halt_s && !at_last_s;
        shift_en_s = 1'b0;
        state_s    = state_r;
        case (state_r)
            ST_IDLE: begin
                state_s = start_ok_s ? ST_RECV : ST_IDLE;
            end
            ST_RECV: begin
                shift_en_s = rx_done;
                state_s    = word_valid_s ? ST_WRITE : ST_RECV;
            end
            ST_WRITE: begin
                shift_en_s = rx_done && continue_s;
                if (continue_s) begin
                    state_s = word_valid_s ? ST_WRITE : ST_RECV;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s = start_ok_s ? ST_RECV : ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, status outputs, address and word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wr_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            addr_r     <= {RAM_ADDR_BITS{1'b0}};
            words_r    <= {(RAM_ADDR_BITS + 1){1'b0}};
        end else begin
            state_r <= state_s;
            wr_en_r <= (state_s == ST_WRITE);
            busy_r  <= (state_s == ST_RECV) || (state_s == ST_WRITE);
            done_r  <= (state_s == ST_DONE);
            if (start_ok_s) begin
                overflow_r <= 1'b0;
                addr_r     <= {RAM_ADDR_BITS{1'b0}};
                words_r    <= {(RAM_ADDR_BITS + 1){1'b0}};
            end else if (state_r == ST_WRITE) begin
                overflow_r <= !is_halt_s && at_last_s;
                addr_r     <= continue_s ? addr_r + {{(RAM_ADDR_BITS - 1){1'b0}}, 1'b1} : addr_r;
                words_r    <= words_r + {{RAM_ADDR_BITS{1'b0}}, 1'b1};
            end else begin
                overflow_r <= overflow_r;
                addr_r     <= addr_r;
                words_r    <= words_r;
            end
        end
    end

    // Write port registers: loaded only when a word completes, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_r <= {RAM_ADDR_BITS{1'b0}};
            wr_data_r <= {RAM_WIDTH{1'b0}};
        end else if (word_valid_s) begin
            wr_addr_r <= (state_r == ST_WRITE) ? addr_r + {{(RAM_ADDR_BITS - 1){1'b0}}, 1'b1} : addr_r;
            wr_data_r <= word_s;
        end else begin
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
        end
    end

    assign wr_en        = wr_en_r;
    assign wr_addr      = wr_addr_r;
    assign wr_data      = wr_data_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign overflow     = overflow_r;
    assign words_loaded = words_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a full-size instance plus a 4-entry
// instance for the memory-full case, with hand-computed expectations.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy, done, overflow;
    logic [11:0] words_loaded;

    logic        s_start = 1'b0;
    logic [7:0]  s_rx_data = 8'h00;
    logic        s_rx_done = 1'b0;
    logic        s_wr_en;
    logic [1:0]  s_wr_addr;
    logic [15:0] s_wr_data;
    logic        s_busy, s_done, s_overflow;
    logic [2:0]  s_words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] swa_q[$];
    logic [31:0] swd_q[$];

    always #5 clk = ~clk;

    program_loader #(.RAM_WIDTH(16), .RAM_ADDR_BITS(11)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_done(rx_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .overflow(overflow), .words_loaded(words_loaded)
    );

    program_loader #(.RAM_WIDTH(16), .RAM_ADDR_BITS(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .rx_data(s_rx_data), .rx_done(s_rx_done),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .busy(s_busy), .done(s_done),
        .overflow(s_overflow), .words_loaded(s_words_loaded)
    );

    // Record every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(32'(wr_addr));
            wd_q.push_back(32'(wr_data));
        end
        if (s_wr_en === 1'b1) begin
            swa_q.push_back(32'(s_wr_addr));
            swd_q.push_back(32'(s_wr_data));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at a negedge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic s_send(input logic [7:0] b);
        s_rx_data = b;
        s_rx_done = 1'b1;
        @(negedge clk);
        s_rx_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Bytes before start are ignored
        send(8'h55, 1'b1);
        send(8'h55, 1'b1);
        chk("idle_no_write", 32'(wa_q.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        pulse_start();
        send(8'h00, 1'b1);
        send(8'h00, 1'b1);
        @(negedge clk);
        chk("halt_only_count", 32'(wa_q.size()), 32'd1);
        chk("halt_only_addr", wa_q[0], 32'd0);
        chk("halt_only_data", wd_q[0], 32'h0000);
        chk("halt_only_words", 32'(words_loaded), 32'd1);
        chk("halt_only_done", 32'(done), 32'd1);

        // Three-word program ending in HALT, with latency checks
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        chk("p1_busy_on_start", 32'(busy), 32'd1);
        chk("p1_done_cleared", 32'(done), 32'd0);
        chk("p1_words_cleared", 32'(words_loaded), 32'd0);
        send(8'h18, 1'b1);
        send(8'h03, 1'b0);
        chk("p1_wr_en_latency", 32'(wr_en), 32'd1);
        chk("p1_wr_addr0", 32'(wr_addr), 32'd0);
        chk("p1_wr_data0", 32'(wr_data), 32'h1803);
        @(negedge clk);
        chk("p1_wr_en_one_cycle", 32'(wr_en), 32'd0);
        chk("p1_addr_held", 32'(wr_addr), 32'd0);
        chk("p1_data_held", 32'(wr_data), 32'h1803);
        chk("p1_words_after0", 32'(words_loaded), 32'd1);
        send(8'h08, 1'b1);
        send(8'h00, 1'b1);
        send(8'h00, 1'b1);
        send(8'h00, 1'b0);
        chk("p1_halt_wr_en", 32'(wr_en), 32'd1);
        chk("p1_done_not_yet", 32'(done), 32'd0);
        @(negedge clk);
        chk("p1_done", 32'(done), 32'd1);
        chk("p1_busy_drop", 32'(busy), 32'd0);
        chk("p1_words", 32'(words_loaded), 32'd3);
        chk("p1_overflow", 32'(overflow), 32'd0);
        chk("p1_count", 32'(wa_q.size()), 32'd3);
        chk("p1_a1", wa_q[1], 32'd1);
        chk("p1_d1", wd_q[1], 32'h0800);
        chk("p1_a2", wa_q[2], 32'd2);
        chk("p1_d2", wd_q[2], 32'h0000);

        // Byte landing in the WRITE cycle, plus a start pulse while busy
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        send(8'h12, 1'b1);
        send(8'h34, 1'b0);
        send(8'hAB, 1'b1);
        chk("ov_words", 32'(words_loaded), 32'd1);
        pulse_start();
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_words", 32'(words_loaded), 32'd1);
        send(8'hCD, 1'b1);
        send(8'h00, 1'b1);
        send(8'h00, 1'b1);
        @(negedge clk);
        chk("ov_count", 32'(wa_q.size()), 32'd3);
        chk("ov_d0", wd_q[0], 32'h1234);
        chk("ov_a1", wa_q[1], 32'd1);
        chk("ov_d1", wd_q[1], 32'hABCD);
        chk("ov_a2", wa_q[2], 32'd2);
        chk("ov_words_end", 32'(words_loaded), 32'd3);
        chk("ov_done", 32'(done), 32'd1);

        // Asynchronous reset mid-load
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_words", 32'(words_loaded), 32'd0);
        chk("ar_wr_addr", 32'(wr_addr), 32'd0);
        chk("ar_wr_data", 32'(wr_data), 32'd0);
        chk("ar_wr_en", 32'(wr_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        send(8'h77, 1'b1);
        send(8'h88, 1'b1);
        send(8'h00, 1'b1);
        send(8'h00, 1'b1);
        @(negedge clk);
        chk("ar_reload_count", 32'(wa_q.size()), 32'd2);
        chk("ar_reload_a0", wa_q[0], 32'd0);
        chk("ar_reload_d0", wd_q[0], 32'h7788);
        chk("ar_reload_words", 32'(words_loaded), 32'd2);

        // Memory full on a 4-entry instance
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            s_send(8'h00);
            s_send(8'(i));
        end
        @(negedge clk);
        chk("full_count", 32'(swa_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("full_addr", swa_q[i], 32'(i));
            chk("full_data", swd_q[i], 32'(i + 1));
        end
        chk("full_done", 32'(s_done), 32'd1);
        chk("full_overflow", 32'(s_overflow), 32'd1);
        chk("full_words", 32'(s_words_loaded), 32'd4);
        s_send(8'h00);
        s_send(8'h05);
        chk("full_no_more", 32'(swa_q.size()), 32'd4);
        chk("full_done_held", 32'(s_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
